uart_rx_deser: RTL and testbench

- Serial-to-parallel UART receiver. Produces the `rdsig`/`rxdata` pair consumed by the UART control logic.
- Samples the asynchronous `rx` line with a clock that is CLKS_PER_BIT times the baud rate.
- Frame format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Flags framing and parity errors and rejects glitch starts.

---
 rtl/uart_rx_deser.sv | 133 +++++++++++++
 tb/tb_uart_rx_deser.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// UART receiver: 2-flop synchronised rx, 3-sample majority vote per bit, 8N1 or 8-bit+parity,
// frame/parity error pulses and a BREAK hold-off for a line stuck low.
module uart_rx_deser #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rxdata,
  output logic       rdsig,
  output logic       frameerror,
  output logic       dataerror,
  output logic       busy
);

  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic          ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t        state_q;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q, rxdata_q;
  logic          samp_a_q, samp_b_q;
  logic          perr_q;
  logic          rdsig_q, ferr_q, derr_q, busy_q;
  logic          maj, samp;

  // Decision is taken at mid+1 using the samples latched at mid-1 and mid plus the live one.
  assign maj  = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);
  assign samp = (cnt_q == MID + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      rxdata_q  <= '0;
      samp_a_q  <= 1'b1;
      samp_b_q  <= 1'b1;
      perr_q    <= 1'b0;
      rdsig_q   <= 1'b0;
      ferr_q    <= 1'b0;
      derr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rdsig_q   <= 1'b0;
      ferr_q    <= 1'b0;
      derr_q    <= 1'b0;

      if (state_q != S_IDLE && state_q != S_BREAK)
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == MID - 1'b1) samp_a_q <= rx_s_q;
      if (cnt_q == MID)        samp_b_q <= rx_s_q;

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        // cnt restarted at the start edge, so letting it wrap keeps every later decision one bit apart.
        S_START: begin
          if (samp) begin
            if (maj) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              bit_q   <= '0;
              perr_q  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (samp) begin
            shreg_q <= {maj, shreg_q[7:1]};
            if (bit_q == 3'd7) state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            else               bit_q   <= bit_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (samp) begin
            perr_q  <= ((^shreg_q) ^ maj) != ODD;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (samp) begin
            if (maj) begin
              rxdata_q <= shreg_q;
              rdsig_q  <= ~perr_q;
              derr_q   <= perr_q;
              state_q  <= S_IDLE;
              busy_q   <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rxdata     = rxdata_q;
  assign rdsig      = rdsig_q;
  assign frameerror = ferr_q;
  assign dataerror  = derr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: one instance without parity, one with even parity.
module tb_uart_rx_deser;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic [7:0] rxdata0, rxdata1;
  logic       rdsig0, fe0, de0, busy0;
  logic       rdsig1, fe1, de1, busy1;

  always #5 clk = ~clk;

  uart_rx_deser #(.CLKS_PER_BIT(CPB), .PARITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .rxdata(rxdata0),
    .rdsig(rdsig0), .frameerror(fe0), .dataerror(de0), .busy(busy0));

  uart_rx_deser #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rxdata(rxdata1),
    .rdsig(rdsig1), .frameerror(fe1), .dataerror(de1), .busy(busy1));

  typedef struct { logic [2:0] code; logic [7:0] data; } exp_t;
  exp_t q0[$], q1[$];
  logic [7:0] last0 = 8'h00, last1 = 8'h00;
  int checks = 0, errors = 0;
  int rdcnt0 = 0, busycnt0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expected pulse kind ({rdsig,frameerror,dataerror}) and rxdata for one frame.
  task automatic model_push(input int which, input logic [7:0] b, input logic pbit, input logic stopv);
    exp_t e;
    logic perr;
    perr = (which == 1) && ((($countones(b) + int'(pbit)) % 2) != 0);
    if (!stopv) begin
      e.code = 3'b010;
      e.data = (which == 0) ? last0 : last1;
    end else begin
      e.code = perr ? 3'b001 : 3'b100;
      e.data = b;
      if (which == 0) last0 = b; else last1 = b;
    end
    if (which == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx0 = v; else rx1 = v;
  endtask

  task automatic idle(input int which, input int nclk);
    set_line(which, 1'b1);
    repeat (nclk) @(negedge clk);
  endtask

  // p100 = bit period in hundredths of a clk; fractional periods accumulate exactly.
  task automatic send_frame(input int which, input logic [7:0] b, input logic pbit,
                            input logic stopv, input int p100);
    logic [10:0] bits;
    int n;
    model_push(which, b, pbit, stopv);
    bits = '0;
    bits[8:1] = b;
    if (which == 1) begin bits[9] = pbit; bits[10] = stopv; n = 11; end
    else            begin bits[9] = stopv; n = 10; end
    for (int i = 0; i < n; i++) begin
      set_line(which, bits[i]);
      repeat (((i + 1) * p100) / 100 - (i * p100) / 100) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy0) busycnt0++;
      if (rdsig0) rdcnt0++;
      if ({rdsig0, fe0, de0} != 3'b000) begin
        if (q0.size() == 0) chk("spurious0", {29'd0, rdsig0, fe0, de0}, 32'd0);
        else begin
          exp_t e;
          e = q0.pop_front();
          chk("kind0", {29'd0, rdsig0, fe0, de0}, {29'd0, e.code});
          chk("data0", {24'd0, rxdata0}, {24'd0, e.data});
        end
      end
      if ({rdsig1, fe1, de1} != 3'b000) begin
        if (q1.size() == 0) chk("spurious1", {29'd0, rdsig1, fe1, de1}, 32'd0);
        else begin
          exp_t e;
          e = q1.pop_front();
          chk("kind1", {29'd0, rdsig1, fe1, de1}, {29'd0, e.code});
          chk("data1", {24'd0, rxdata1}, {24'd0, e.data});
        end
      end
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    string s;
    int rd_before, k;
    logic [7:0] b;
    logic pb, st;
    int w, p;

    s = "Hello NEXYS 4 DDR\n\r";
    repeat (3) @(negedge clk);
    chk("rst_rxdata", {24'd0, rxdata0}, 32'h00);
    chk("rst_pulses", {29'd0, rdsig0, fe0, de0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    busycnt0 = 0;
    send_frame(0, 8'h48, 1'b0, 1'b1, 1600);
    idle(0, 2 * CPB);
    chk("h_rxdata", {24'd0, rxdata0}, 32'h48);
    chk("h_busy_len", {31'd0, (busycnt0 >= 9 * CPB) && (busycnt0 <= 11 * CPB)}, 32'd1);

    rd_before = rdcnt0;
    for (int i = 0; i < s.len(); i++) send_frame(0, s[i], 1'b0, 1'b1, 1600);
    idle(0, 3 * CPB);
    chk("str_count", rdcnt0 - rd_before, s.len());
    chk("str_last", {24'd0, rxdata0}, 32'h0D);

    rx0 = 1'b0;
    repeat (5) @(negedge clk);
    rx0 = 1'b1;
    k = 0;
    while (busy0 && k < CPB / 2 + 3) begin @(negedge clk); k++; end
    chk("false_busy", {31'd0, busy0}, 32'd0);
    idle(0, 2 * CPB);

    send_frame(0, 8'hA5, 1'b0, 1'b0, 1600);
    repeat (3 * CPB) @(negedge clk);
    chk("break_busy", {31'd0, busy0}, 32'd1);
    chk("break_rxdata", {24'd0, rxdata0}, 32'h0D);
    idle(0, CPB);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1600);
    idle(0, 2 * CPB);
    chk("after_break", {24'd0, rxdata0}, 32'h3C);

    send_frame(1, 8'h07, 1'b1, 1'b1, 1600);
    send_frame(1, 8'h07, 1'b0, 1'b1, 1600);
    idle(1, 2 * CPB);
    chk("par_rxdata", {24'd0, rxdata1}, 32'h07);

    for (int i = 0; i < 40; i++) begin
      w  = int'($urandom_range(0, 1));
      b  = 8'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 7) != 0);
      p  = int'($urandom_range(1552, 1648));
      send_frame(w, b, pb, st, p);
      if (!st) begin
        repeat (int'($urandom_range(0, 2)) * CPB) @(negedge clk);
        idle(w, CPB);
      end else begin
        idle(w, int'($urandom_range(0, 2)) * CPB);
      end
    end
    idle(0, 2 * CPB);
    idle(1, 2 * CPB);

    send_frame(0, 8'h5A, 1'b0, 1'b1, 1600);
    idle(0, 2 * CPB);
    rx0 = 1'b0;
    repeat (CPB) @(negedge clk);
    rx0 = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    chk("mid_busy", {31'd0, busy0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rxdata", {24'd0, rxdata0}, 32'h00);
    chk("async_busy", {31'd0, busy0}, 32'd0);
    last0 = 8'h00;
    last1 = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(0, 2 * CPB);
    send_frame(0, 8'h55, 1'b0, 1'b1, 1600);
    idle(0, 2 * CPB);
    chk("post_rst", {24'd0, rxdata0}, 32'h55);
    send_frame(0, 8'h55, 1'b0, 1'b1, 1648);
    idle(0, 2 * CPB);
    send_frame(0, 8'h55, 1'b0, 1'b1, 1552);
    idle(0, 2 * CPB);
    chk("tol_rxdata", {24'd0, rxdata0}, 32'h55);

    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 200) begin @(negedge clk); k++; end
    chk("drain0", q0.size(), 32'd0);
    chk("drain1", q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
